// File: rtl/lfsr_msg_decoder_pkg.sv
// lfsr_msg_decoder_pkg: shared FSM state type, the nine candidate tap patterns and the LFSR step helpers.
package lfsr_msg_decoder_pkg;
  typedef enum logic [2:0] {IDLE, SEED, SRCH, DRD, DWR, DONE} dec_state_t;
  localparam int NPTRN = 9;
  localparam logic [6:0] LFSR_PTRN [NPTRN] = '{7'h60, 7'h48, 7'h78, 7'h72, 7'h6A, 7'h69, 7'h5C, 7'h7E, 7'h7B};
  function automatic logic [6:0] step(input logic [6:0] s, input logic [6:0] p);
    return {s[5:0], ^(s & p)};
  endfunction
  // Index past the last candidate yields an all-zero pattern instead of an out-of-range read.
  function automatic logic [6:0] ptrn_of(input logic [3:0] k);
    return k < 4'(NPTRN) ? LFSR_PTRN[k] : '0;
  endfunction
endpackage

// File: rtl/lfsr_msg_decoder_if.sv
// lfsr_msg_decoder_if: req/ack handshake, run status and data-memory bus of the decoder.
//   master: decoder side (drives ack/err/ptrn_idx/pre_len and the DM address/write signals)
//   slave : host/memory side (drives req and dm_rd_data)
interface lfsr_msg_decoder_if #(parameter int AW = 8);
  logic          req;
  logic          ack;
  logic          err;
  logic [3:0]    ptrn_idx;
  logic [6:0]    pre_len;
  logic [AW-1:0] dm_addr;
  logic [7:0]    dm_rd_data;
  logic          dm_wr_en;
  logic [7:0]    dm_wr_data;
  modport master (input req, dm_rd_data, output ack, err, ptrn_idx, pre_len, dm_addr, dm_wr_en, dm_wr_data);
  modport slave (output req, dm_rd_data, input ack, err, ptrn_idx, pre_len, dm_addr, dm_wr_en, dm_wr_data);
endinterface

// File: rtl/lfsr_msg_decoder_lfsr7.sv
// lfsr7: 7-bit register shared as search prediction and decryption keystream.
//   clk, init_n : clock, async active-low reset
//   load, d     : parallel load (priority over step)
//   stp, ptrn   : advance one LFSR step with tap pattern ptrn
//   q           : current state
module lfsr7
  import lfsr_msg_decoder_pkg::*;
(
  input  logic       clk,
  input  logic       init_n,
  input  logic       load,
  input  logic [6:0] d,
  input  logic       stp,
  input  logic [6:0] ptrn,
  output logic [6:0] q
);
  always_ff @(posedge clk or negedge init_n)
    if (!init_n) q <= '0;
    else q <= load ? d : stp ? step(q, ptrn) : q;
endmodule

// File: rtl/lfsr_msg_decoder.sv
// lfsr_msg_decoder: recovers LFSR seed/taps from a space preamble and decrypts a DM message in place.
//   clk, init_n : clock, async active-low reset
//   bus         : lfsr_msg_decoder_if.master (req/ack handshake, err/ptrn_idx/pre_len status, DM bus)
module lfsr_msg_decoder
  import lfsr_msg_decoder_pkg::*;
#(
  parameter int AW       = 8,
  parameter int BASE_IN  = 64,
  parameter int BASE_OUT = 0,
  parameter int MSG_LEN  = 64,
  parameter int PRE_MIN  = 10
) (
  input logic clk,
  input logic init_n,
  lfsr_msg_decoder_if.master bus
);
  dec_state_t state;
  logic       req_q, ack, err, pre_all;
  logic [3:0] k, ptrn_idx;
  logic [5:0] i;
  logic [6:0] seed, pred, pre_len, d;
  logic [7:0] b;
  logic       load, stp, match, last;
  logic [6:0] rd7;
  assign rd7   = bus.dm_rd_data[6:0];
  assign match = rd7 == pred;
  assign last  = i == 6'(PRE_MIN - 1);
  // Search restarts a candidate from the seed; a full preamble match reloads the seed for decryption.
  assign load  = state == SEED || (state == SRCH && (match ? last : k != 4'd8));
  assign d     = state == SEED ? step(rd7, ptrn_of(4'd0)) : match ? seed : step(seed, ptrn_of(k + 4'd1));
  assign stp   = (state == SRCH && match && !last) || state == DWR;
  lfsr7 u_lfsr (.clk(clk), .init_n(init_n), .load(load), .d(d), .stp(stp), .ptrn(ptrn_of(k)), .q(pred));
  always_ff @(posedge clk or negedge init_n)
    if (!init_n) begin
      state    <= IDLE;
      req_q    <= 1'b0;
      ack      <= 1'b0;
      err      <= 1'b0;
      pre_all  <= 1'b0;
      k        <= '0;
      ptrn_idx <= '0;
      i        <= '0;
      seed     <= '0;
      pre_len  <= '0;
      b        <= '0;
    end else begin
      req_q <= bus.req;
      case (state)
        IDLE: if (bus.req && !req_q) begin
          state    <= SEED;
          err      <= 1'b0;
          ptrn_idx <= '0;
          pre_len  <= '0;
          pre_all  <= 1'b1;
        end
        SEED: begin
          seed <= rd7;
          k    <= '0;
          i    <= 6'd1;
          if (rd7 == '0) begin
            err   <= 1'b1;
            ack   <= 1'b1;
            state <= DONE;
          end else state <= SRCH;
        end
        SRCH: if (!match) begin
          if (k == 4'd8) begin
            err   <= 1'b1;
            ack   <= 1'b1;
            state <= DONE;
          end else begin
            k <= k + 4'd1;
            i <= 6'd1;
          end
        end else if (last) begin
          ptrn_idx <= k;
          i        <= '0;
          state    <= DRD;
        end else i <= i + 6'd1;
        DRD: begin
          b     <= 8'({1'b0, rd7 ^ pred}) + 8'h20;
          state <= DWR;
        end
        DWR: begin
          if (pre_all && b == 8'h20) pre_len <= pre_len + 7'd1;
          else pre_all <= 1'b0;
          if (i == 6'(MSG_LEN - 1)) begin
            ack   <= 1'b1;
            state <= DONE;
          end else begin
            i     <= i + 6'd1;
            state <= DRD;
          end
        end
        DONE: if (!bus.req) begin
          ack   <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  assign bus.ack        = ack;
  assign bus.err        = err;
  assign bus.ptrn_idx   = ptrn_idx;
  assign bus.pre_len    = pre_len;
  assign bus.dm_wr_en   = state == DWR;
  assign bus.dm_wr_data = state == DWR ? b : '0;
  assign bus.dm_addr    = state == SEED ? AW'(BASE_IN)
                        : (state == SRCH || state == DRD) ? AW'(BASE_IN) + AW'(i)
                        : state == DWR ? AW'(BASE_OUT) + AW'(i) : '0;
endmodule

// File: tb/tb_lfsr_msg_decoder.sv
// tb_lfsr_msg_decoder: directed bench with write scoreboard for lfsr_msg_decoder.
module tb_lfsr_msg_decoder;
  logic clk = 1'b0;
  logic init_n = 1'b0;
  logic clr = 1'b0;
  always #5 clk = ~clk;
  lfsr_msg_decoder_if #(.AW(8)) bus ();
  lfsr_msg_decoder dut (.clk(clk), .init_n(init_n), .bus(bus));
  logic [7:0] mem [256];
  logic [7:0] out_mem [64];
  logic [7:0] exp_p [64];
  logic [15:0] sb [$];
  int nchk = 0, nfail = 0, wcnt = 0;
  assign bus.dm_rd_data = mem[bus.dm_addr];
  always @(posedge clk)
    if (clr) for (int j = 0; j < 64; j++) out_mem[j] <= 8'hEE;
    else if (bus.dm_wr_en && bus.dm_addr < 8'd64) out_mem[bus.dm_addr[5:0]] <= bus.dm_wr_data;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    nchk++;
    assert (got === want) else begin
      nfail++;
      $error("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask
  always @(negedge clk)
    if (init_n && bus.dm_wr_en) begin
      logic [15:0] e;
      wcnt++;
      e = sb.size() != 0 ? sb.pop_front() : 16'hFFFF;
      chk("wr_addr", {24'd0, bus.dm_addr}, {24'd0, e[15:8]});
      chk("wr_data", {24'd0, bus.dm_wr_data}, {24'd0, e[7:0]});
    end
  task automatic encrypt(input string msg, input int pre, input logic [6:0] init, input logic [6:0] ptrn);
    logic [6:0] s;
    logic [7:0] p, c;
    s = init;
    for (int j = 0; j < 64; j++) begin
      p = j < pre ? 8'h20 : (j - pre < msg.len()) ? msg[j - pre] : 8'h20;
      exp_p[j] = p;
      c = p - 8'h20;
      mem[64 + j] = {1'b0, c[6:0] ^ s};
      s = {s[5:0], ^(s & ptrn)};
    end
  endtask
  task automatic launch(input bit err_run);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    sb.delete();
    wcnt = 0;
    if (!err_run) for (int j = 0; j < 64; j++) sb.push_back({8'(j), exp_p[j]});
    bus.req = 1'b1;
  endtask
  task automatic wait_ack(input string tag, output int cyc);
    cyc = 0;
    while (!bus.ack && cyc < 400) begin
      @(negedge clk);
      cyc++;
    end
    chk({tag, "_ack"}, {31'd0, bus.ack}, 32'd1);
  endtask
  task automatic finish_run(input string tag, input bit e_err, input int e_idx, input int e_pre, input int e_lat);
    int cyc;
    wait_ack(tag, cyc);
    if (e_lat >= 0) chk({tag, "_lat"}, cyc, e_lat);
    chk({tag, "_err"}, {31'd0, bus.err}, {31'd0, e_err});
    chk({tag, "_idx"}, {28'd0, bus.ptrn_idx}, e_idx);
    chk({tag, "_pre"}, {25'd0, bus.pre_len}, e_pre);
    chk({tag, "_wcnt"}, wcnt, e_err ? 0 : 64);
    chk({tag, "_sb"}, sb.size(), 0);
    if (!e_err) begin
      int bad = 0;
      for (int j = 0; j < 64; j++) if (out_mem[j] !== exp_p[j]) bad++;
      chk({tag, "_dm"}, bad, 0);
    end
    bus.req = 1'b0;
    @(negedge clk);
    chk({tag, "_ackclr"}, {31'd0, bus.ack}, 32'd0);
  endtask
  task automatic chk_reset(input string tag);
    chk({tag, "_ack"}, {31'd0, bus.ack}, 32'd0);
    chk({tag, "_err"}, {31'd0, bus.err}, 32'd0);
    chk({tag, "_idx"}, {28'd0, bus.ptrn_idx}, 32'd0);
    chk({tag, "_pre"}, {25'd0, bus.pre_len}, 32'd0);
    chk({tag, "_we"}, {31'd0, bus.dm_wr_en}, 32'd0);
    chk({tag, "_addr"}, {24'd0, bus.dm_addr}, 32'd0);
    chk({tag, "_wd"}, {24'd0, bus.dm_wr_data}, 32'd0);
  endtask
  localparam string M1 = "Mr. Watson, come here. I want to see you.";
  localparam string M2 = "Come here, I want to see you";
  initial begin
    int cyc, w0;
    bus.req = 1'b0;
    for (int j = 0; j < 256; j++) mem[j] = 8'h00;
    repeat (3) @(negedge clk);
    chk_reset("rst");
    init_n = 1'b1;
    @(negedge clk);
    // T1
    encrypt(M1, 10, 7'h01, 7'h7B);
    launch(1'b0);
    finish_run("t1", 1'b0, 8, 10, -1);
    // T2: pattern 0 matches on the first pass, 9 search reads
    encrypt(M2, 26, 7'h7F, 7'h60);
    launch(1'b0);
    finish_run("t2", 1'b0, 0, 26, 139);
    // T3: zero seed
    for (int j = 64; j < 128; j++) mem[j] = 8'h00;
    launch(1'b1);
    finish_run("t3", 1'b1, 0, 0, 2);
    // T4: corrupted preamble byte
    encrypt(M1, 10, 7'h01, 7'h7B);
    mem[69] = mem[69] ^ 8'h01;
    launch(1'b1);
    finish_run("t4", 1'b1, 0, 0, -1);
    // T5: reset during the write of byte 20
    encrypt(M1, 10, 7'h01, 7'h7B);
    launch(1'b0);
    cyc = 0;
    while (!(bus.dm_wr_en && bus.dm_addr == 8'd20) && cyc < 400) begin
      @(negedge clk);
      cyc++;
    end
    chk("t5_reach", {31'd0, bus.dm_wr_en}, 32'd1);
    init_n = 1'b0;
    #1;
    chk("t5_we", {31'd0, bus.dm_wr_en}, 32'd0);
    chk("t5_ack", {31'd0, bus.ack}, 32'd0);
    bus.req = 1'b0;
    sb.delete();
    @(negedge clk);
    chk_reset("t5rst");
    init_n = 1'b1;
    @(negedge clk);
    launch(1'b0);
    wait_ack("t5re", cyc);
    chk("t5re_idx", {28'd0, bus.ptrn_idx}, 32'd8);
    chk("t5re_pre", {25'd0, bus.pre_len}, 32'd10);
    chk("t5re_wcnt", wcnt, 64);
    // T6: req held high past ack
    w0 = wcnt;
    cyc = 0;
    repeat (100) begin
      @(negedge clk);
      if (bus.ack) cyc++;
    end
    chk("t6_hold", cyc, 100);
    chk("t6_nowr", wcnt, w0);
    chk("t6_sb", sb.size(), 0);
    bus.req = 1'b0;
    @(negedge clk);
    chk("t6_ackclr", {31'd0, bus.ack}, 32'd0);
    encrypt(M2, 26, 7'h7F, 7'h60);
    launch(1'b0);
    finish_run("t6re", 1'b0, 0, 26, 139);
    $display("%0d/%0d checks passed", nchk - nfail, nchk);
    $finish;
  end
endmodule
